fetch_mem_arbiter: RTL

//  Shares one single-ported unified instruction/data memory between the fetch stage (IF) and
//  the memory stage (MEM) of the 5-stage RV32 pipeline. Grants one transaction at a time,

---
 rtl/fetch_mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one single-ported unified memory between instruction fetch and data access.
// Latency: a grant registers the memory request; completion is combinational with mem_ack (1 cycle minimum).
// Backpressure: each requester sees StallF/StallM until its access completes; one transaction at a time.
module fetch_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   // fetch port
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   output logic                StallF,
   // data port
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [DATA_W/8-1:0] dm_be,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_valid,
   output logic                StallM,
   // memory port
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack
);

   localparam int         BE_W       = DATA_W / 8;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t     state;
   state_t     stateNext;
   logic [3:0] starveCnt;
   logic [3:0] starveNext;
   logic       kill;
   logic       killNext;
   logic       decide;
   logic       grantD;
   logic       grantI;

   // Read data is shared; each requester only looks at it with its own valid.
   assign if_rdata = mem_rdata;
   assign dm_rdata = mem_rdata;

   // Completion pulses; a fetch killed by a branch (now or earlier) never reports valid.
   assign if_valid = (state == BUSY_I) && mem_ack && !kill && !flush;
   assign dm_valid = (state == BUSY_D) && mem_ack;

   // A requester stalls until the cycle its access completes.
   assign StallF = if_req && !if_valid;
   assign StallM = dm_req && !dm_valid;

   // Next-state, grant selection, kill tracking and fetch-starvation counting.
   always_comb begin
      stateNext  = state;
      grantD     = 1'b0;
      grantI     = 1'b0;
      killNext   = kill;
      starveNext = starveCnt;
      // Decide when free, or back-to-back in the cycle the current access is acknowledged.
      decide     = (state == IDLE) || mem_ack;

      if (decide) begin
         if (dm_req && ((starveCnt < STARVE_LIM) || !if_req)) begin
            grantD = 1'b1;
         end else if (if_req && !flush) begin
            grantI = 1'b1;
         end

         if (grantD) begin
            stateNext = BUSY_D;
         end else if (grantI) begin
            stateNext = BUSY_I;
         end else begin
            stateNext = IDLE;
         end
      end

      // A branch during an outstanding fetch marks it dead; its ack is swallowed.
      if (state == BUSY_I) begin
         if (mem_ack) begin
            killNext = 1'b0;
         end else if (flush) begin
            killNext = 1'b1;
         end
      end

      // Count data grants that jumped ahead of a waiting fetch.
      if (!if_req || grantI) begin
         starveNext = 4'd0;
      end else if (grantD && (starveCnt != STARVE_LIM)) begin
         starveNext = starveCnt + 4'd1;
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         kill      <= 1'b0;
         starveCnt <= 4'd0;
      end else begin
         state     <= stateNext;
         kill      <= killNext;
         starveCnt <= starveNext;
      end
   end

   // Memory request registers: loaded on a grant, held until the ack, request dropped when nothing wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
      end else if (decide) begin
         mem_req <= grantD || grantI;
         if (grantD) begin
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
         end else if (grantI) begin
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            mem_be   <= {BE_W{1'b1}};
         end
      end
   end

endmodule
